cache_mem_transfer_buffer: RTL and testbench

//  Transfer stage between a cache controller and the internal memory controller. It presents

---
 rtl/cache_mem_transfer_buffer_pkg.sv | 17 +
 rtl/cache_mem_transfer_buffer_if.sv | 43 ++++
 rtl/cache_mem_transfer_buffer_fifo.sv | 56 +++++
 rtl/cache_mem_transfer_buffer.sv | 141 ++++++++++++++
 tb/tb_cache_mem_transfer_buffer.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_mem_transfer_buffer_pkg.sv
// Shared constants, FSM state encodings and command type for the cache/memory transfer buffer.
package cache_mem_transfer_buffer_pkg;

    localparam int BW_BLOCK     = 2;
    localparam int BW_WORD_ADDR = 30;

    localparam logic [1:0] ID_XFER_IDLE  = 2'd0;
    localparam logic [1:0] ID_XFER_ISSUE = 2'd1;
    localparam logic [1:0] ID_XFER_WR    = 2'd2;
    localparam logic [1:0] ID_XFER_RD    = 2'd3;

    typedef struct packed {
        logic block;
        logic rw;
    } xfer_cmd_t;

endpackage

// File: rtl/cache_mem_transfer_buffer_if.sv
// Cache-side and memory-side signal bundle; slave is the buffer's view, master the environment's.
interface cache_mem_transfer_buffer_if #(
    parameter int BW_ADDR = cache_mem_transfer_buffer_pkg::BW_WORD_ADDR
);
    logic               req_i;
    logic               req_block_i;
    logic               rw_i;
    logic [BW_ADDR-1:0] add_i;
    logic               write_i;
    logic [31:0]        data_i;
    logic               read_i;
    logic               ready_req_o;
    logic               ready_write_o;
    logic               ready_read_o;
    logic [31:0]        data_o;
    logic               mem_req_o;
    logic               mem_rw_o;
    logic               mem_block_o;
    logic [BW_ADDR-1:0] mem_add_o;
    logic               mem_ack_i;
    logic               mem_wvalid_o;
    logic [31:0]        mem_wdata_o;
    logic               mem_wready_i;
    logic               mem_rvalid_i;
    logic [31:0]        mem_rdata_i;
    logic               err_o;

    modport slave (
        input  req_i, req_block_i, rw_i, add_i, write_i, data_i, read_i,
               mem_ack_i, mem_wready_i, mem_rvalid_i, mem_rdata_i,
        output ready_req_o, ready_write_o, ready_read_o, data_o,
               mem_req_o, mem_rw_o, mem_block_o, mem_add_o,
               mem_wvalid_o, mem_wdata_o, err_o
    );

    modport master (
        output req_i, req_block_i, rw_i, add_i, write_i, data_i, read_i,
               mem_ack_i, mem_wready_i, mem_rvalid_i, mem_rdata_i,
        input  ready_req_o, ready_write_o, ready_read_o, data_o,
               mem_req_o, mem_rw_o, mem_block_o, mem_add_o,
               mem_wvalid_o, mem_wdata_o, err_o
    );
endinterface

// File: rtl/cache_mem_transfer_buffer_fifo.sv
// Show-ahead synchronous FIFO; an illegal push or pop is silently ignored here and flagged by the caller.
module cache_xfer_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           din_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_COUNT = DEPTH[PTR_W:0];
    localparam logic [PTR_W:0]   CNT_ONE    = 1;
    localparam logic [PTR_W-1:0] PTR_ONE    = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_COUNT);
    assign count_o = count_q;
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // When full, a simultaneous pop frees the slot the push lands in.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // NOTE: storage has no reset; pointers and count define what is valid, and dout is masked when empty.
    always_ff @(posedge clock_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/cache_mem_transfer_buffer.sv
// Transfer stage between cache controller and memory controller: one command in flight,
// a read FIFO for fill words and a write FIFO for write-back words.
module cache_mem_transfer_buffer
    import cache_mem_transfer_buffer_pkg::*;
#(
    parameter int BLOCK_WORDS = 1 << BW_BLOCK,
    parameter int FIFO_DEPTH  = 16,
    parameter int BW_ADDR     = BW_WORD_ADDR
) (
    input logic                        clock_i,
    input logic                        reset_i,
    cache_mem_transfer_buffer_if.slave bus
);
    localparam int CNT_W  = $clog2(BLOCK_WORDS) + 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] ONE = 1;

    logic [1:0]         state_q, state_d;
    xfer_cmd_t          cmd_q, cmd_d;
    logic [BW_ADDR-1:0] add_q, add_d;
    logic [CNT_W-1:0]   beat_q, beat_d, pushed_q, pushed_d, n_words;
    logic               err_q, err_d;

    logic              rf_push, rf_full, rf_empty;
    logic              wf_push, wf_pop, wf_full, wf_empty;
    logic [FCNT_W-1:0] rf_count, wf_count;
    logic [31:0]       rf_dout, wf_dout;

    logic ready_req, ready_write, wr_open, wvalid, rd_ok;

    cache_xfer_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_rfifo (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .push_i  (rf_push),
        .pop_i   (bus.read_i),
        .din_i   (bus.mem_rdata_i),
        .dout_o  (rf_dout),
        .full_o  (rf_full),
        .empty_o (rf_empty),
        .count_o (rf_count)
    );

    cache_xfer_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_wfifo (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .push_i  (wf_push),
        .pop_i   (wf_pop),
        .din_i   (bus.data_i),
        .dout_o  (wf_dout),
        .full_o  (wf_full),
        .empty_o (wf_empty),
        .count_o (wf_count)
    );

    assign n_words = cmd_q.block ? CNT_W'(BLOCK_WORDS) : ONE;

    // An undrained fill blocks new commands; the write FIFO is always empty here, checked defensively.
    assign ready_req   = (state_q == ID_XFER_IDLE) & (rf_count == '0) & (wf_count == '0);
    assign wr_open     = cmd_q.rw & ((state_q == ID_XFER_ISSUE) | (state_q == ID_XFER_WR));
    assign ready_write = wr_open & ~wf_full & (pushed_q < n_words);
    assign wf_push     = bus.write_i & ready_write;
    assign wvalid      = (state_q == ID_XFER_WR) & ~wf_empty;
    assign wf_pop      = wvalid & bus.mem_wready_i;

    // RD is left on the N-th word, so being in RD already implies the beat limit is not reached.
    assign rd_ok   = (state_q == ID_XFER_RD) & (~rf_full | (bus.read_i & ~rf_empty));
    assign rf_push = bus.mem_rvalid_i & rd_ok;

    assign err_d = err_q
                 | (bus.write_i & ~ready_write)
                 | (bus.read_i & rf_empty)
                 | (bus.mem_rvalid_i & ~rd_ok);

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        add_d    = add_q;
        beat_d   = beat_q;
        pushed_d = wf_push ? pushed_q + ONE : pushed_q;
        case (state_q)
            ID_XFER_IDLE: begin
                if (bus.req_i && ready_req) begin
                    state_d  = ID_XFER_ISSUE;
                    cmd_d    = '{block: bus.req_block_i, rw: bus.rw_i};
                    add_d    = bus.add_i;
                    pushed_d = '0;
                end
            end
            ID_XFER_ISSUE: begin
                if (bus.mem_ack_i) begin
                    state_d = cmd_q.rw ? ID_XFER_WR : ID_XFER_RD;
                    beat_d  = '0;
                end
            end
            ID_XFER_WR: begin
                if (wf_pop) begin
                    beat_d = beat_q + ONE;
                    if (beat_q == n_words - ONE) state_d = ID_XFER_IDLE;
                end
            end
            ID_XFER_RD: begin
                if (rf_push) begin
                    beat_d = beat_q + ONE;
                    if (beat_q == n_words - ONE) state_d = ID_XFER_IDLE;
                end
            end
            default: state_d = ID_XFER_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ID_XFER_IDLE;
            cmd_q    <= '0;
            add_q    <= '0;
            beat_q   <= '0;
            pushed_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            add_q    <= add_d;
            beat_q   <= beat_d;
            pushed_q <= pushed_d;
            err_q    <= err_d;
        end
    end

    assign bus.ready_req_o   = ready_req;
    assign bus.ready_write_o = ready_write;
    assign bus.ready_read_o  = ~rf_empty;
    assign bus.data_o        = rf_dout;
    assign bus.mem_req_o     = (state_q == ID_XFER_ISSUE);
    assign bus.mem_rw_o      = cmd_q.rw;
    assign bus.mem_block_o   = cmd_q.block;
    assign bus.mem_add_o     = add_q;
    assign bus.mem_wvalid_o  = wvalid;
    assign bus.mem_wdata_o   = wf_dout;
    assign bus.err_o         = err_q;
endmodule

// File: tb/tb_cache_mem_transfer_buffer.sv
// Self-checking bench: queue-based reference of the cache/memory word streams, randomized traffic.
module tb_cache_mem_transfer_buffer;
    import cache_mem_transfer_buffer_pkg::*;

    localparam int BW_ADDR     = BW_WORD_ADDR;
    localparam int BLOCK_WORDS = 1 << BW_BLOCK;
    localparam int FIFO_DEPTH  = 4;
    localparam int TIMEOUT     = 200;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] exp_q [$];
    logic [31:0] wq    [$];

    always #5 clk = ~clk;

    cache_mem_transfer_buffer_if #(.BW_ADDR(BW_ADDR)) bus ();

    cache_mem_transfer_buffer #(
        .BLOCK_WORDS (BLOCK_WORDS),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .BW_ADDR     (BW_ADDR)
    ) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.req_i        = 1'b0;
        bus.req_block_i  = 1'b0;
        bus.rw_i         = 1'b0;
        bus.add_i        = '0;
        bus.write_i      = 1'b0;
        bus.data_i       = '0;
        bus.read_i       = 1'b0;
        bus.mem_ack_i    = 1'b0;
        bus.mem_wready_i = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
    endtask

    task automatic apply_reset();
        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        step();
        exp_q.delete();
    endtask

    // Places a command and checks the downstream fields it latched.
    task automatic send_req(input logic blk, input logic rw, input logic [BW_ADDR-1:0] addr);
        bus.req_i       = 1'b1;
        bus.req_block_i = blk;
        bus.rw_i        = rw;
        bus.add_i       = addr;
        step();
        bus.req_i       = 1'b0;
        bus.req_block_i = $urandom_range(0, 1);
        bus.rw_i        = $urandom_range(0, 1);
        bus.add_i       = BW_ADDR'($urandom);
        checks++;
        if ({bus.mem_req_o, bus.mem_block_o, bus.mem_rw_o, bus.mem_add_o} !== {1'b1, blk, rw, addr}) begin
            errors++;
            $display("FAIL issue_cmd: got req/blk/rw/add %b/%b/%b/%h want 1/%b/%b/%h",
                     bus.mem_req_o, bus.mem_block_o, bus.mem_rw_o, bus.mem_add_o, blk, rw, addr);
        end
    endtask

    task automatic ack_after(input int delay);
        repeat (delay) step();
        bus.mem_ack_i = 1'b1;
        step();
        bus.mem_ack_i = 1'b0;
        checks++;
        if (bus.mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL ack_release: mem_req_o got %b want 0", bus.mem_req_o);
        end
    endtask

    // Memory returns n words (random gaps); the cache optionally drains at random. Model: a FIFO queue.
    task automatic read_fill(input int n, input int gap, input bit drain);
        int sent = 0;
        int cyc  = 0;
        while ((sent < n || (drain && exp_q.size() > 0)) && cyc < TIMEOUT) begin
            bus.mem_rvalid_i = (sent < n) && ($urandom_range(0, gap) == 0);
            bus.mem_rdata_i  = $urandom;
            bus.read_i       = drain && bus.ready_read_o && ($urandom_range(0, 1) == 1);
            if (bus.read_i) void'(exp_q.pop_front());
            if (bus.mem_rvalid_i) begin
                exp_q.push_back(bus.mem_rdata_i);
                sent++;
            end
            step();
            cyc++;
            checks++;
            if (bus.ready_read_o !== (exp_q.size() != 0) ||
                (exp_q.size() != 0 && bus.data_o !== exp_q[0])) begin
                errors++;
                $display("FAIL read_stream: got ready_read=%b data=%h want ready_read=%0b data=%h",
                         bus.ready_read_o, bus.data_o, exp_q.size() != 0,
                         (exp_q.size() != 0) ? exp_q[0] : 32'h0);
            end
        end
        drive_idle();
        checks++;
        if (cyc >= TIMEOUT) begin
            errors++;
            $display("FAIL read_timeout: got %0d cycles want < %0d", cyc, TIMEOUT);
        end
    endtask

    // Cache pushes the words in wq from ISSUE onward; memory must see them in order.
    task automatic write_back(input logic blk, input int ack_delay, input bit toggle);
        int n      = blk ? BLOCK_WORDS : 1;
        int pushed = 0;
        int got    = 0;
        int cyc    = 0;
        send_req(blk, 1'b1, BW_ADDR'($urandom));
        checks++;
        if (bus.ready_write_o !== 1'b1) begin
            errors++;
            $display("FAIL ready_write_issue: got %b want 1", bus.ready_write_o);
        end
        while ((got < n || bus.ready_req_o !== 1'b1) && cyc < TIMEOUT) begin
            bus.mem_ack_i    = (cyc == ack_delay);
            bus.write_i      = (pushed < n) && bus.ready_write_o && ($urandom_range(0, 3) != 0);
            bus.data_i       = (pushed < n) ? wq[pushed] : 32'h0;
            if (bus.write_i) pushed++;
            bus.mem_wready_i = toggle ? (cyc % 2 == 0) : ($urandom_range(0, 1) == 1);
            if (bus.mem_wvalid_o && bus.mem_wready_i) begin
                checks++;
                if (got >= n || bus.mem_wdata_o !== wq[got]) begin
                    errors++;
                    $display("FAIL wb_data[%0d]: got %h want %h", got, bus.mem_wdata_o,
                             (got < n) ? wq[got] : 32'h0);
                end
                got++;
            end
            step();
            cyc++;
        end
        drive_idle();
        checks++;
        if (cyc >= TIMEOUT || {bus.mem_wvalid_o, bus.ready_write_o} !== 2'b00) begin
            errors++;
            $display("FAIL wb_done: got cycles=%0d wvalid=%b ready_write=%b want < %0d, 0, 0",
                     cyc, bus.mem_wvalid_o, bus.ready_write_o, TIMEOUT);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({bus.ready_req_o, bus.ready_write_o, bus.ready_read_o, bus.mem_req_o,
             bus.mem_wvalid_o, bus.err_o} !== 6'b100000 || bus.data_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: got rq/rw/rr/mreq/wv/err=%b%b%b%b%b%b data=%h want 100000 data=0",
                     bus.ready_req_o, bus.ready_write_o, bus.ready_read_o, bus.mem_req_o,
                     bus.mem_wvalid_o, bus.err_o, bus.data_o);
        end
    endtask

    task automatic test_single_read();
        send_req(1'b0, 1'b0, BW_ADDR'(32'h100));
        ack_after(2);
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hDEADBEEF;
        step();
        drive_idle();
        checks++;
        if ({bus.ready_read_o, bus.ready_req_o} !== 2'b10 || bus.data_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_read_data: got rr=%b rq=%b data=%h want rr=1 rq=0 data=deadbeef",
                     bus.ready_read_o, bus.ready_req_o, bus.data_o);
        end
        bus.read_i = 1'b1;
        step();
        bus.read_i = 1'b0;
        checks++;
        if ({bus.ready_read_o, bus.ready_req_o, bus.err_o} !== 3'b010) begin
            errors++;
            $display("FAIL single_read_drain: got rr/rq/err=%b%b%b want 010",
                     bus.ready_read_o, bus.ready_req_o, bus.err_o);
        end
    endtask

    task automatic test_block_write();
        wq.delete();
        for (int i = 1; i <= BLOCK_WORDS; i++) wq.push_back(32'(i));
        write_back(1'b1, 2, 1'b1);
        checks++;
        if (bus.err_o !== 1'b0) begin
            errors++;
            $display("FAIL block_write_err: got %b want 0", bus.err_o);
        end
        bus.write_i = 1'b1;
        bus.data_i  = 32'h5;
        step();
        drive_idle();
        checks++;
        if ({bus.err_o, bus.mem_wvalid_o} !== 2'b10) begin
            errors++;
            $display("FAIL extra_write_err: got err=%b wvalid=%b want err=1 wvalid=0",
                     bus.err_o, bus.mem_wvalid_o);
        end
        apply_reset();
    endtask

    task automatic test_slow_fill();
        send_req(1'b1, 1'b0, BW_ADDR'($urandom));
        ack_after(1);
        read_fill(BLOCK_WORDS, 0, 1'b0);
        checks++;
        if ({bus.ready_read_o, bus.ready_req_o, bus.mem_req_o} !== 3'b100 ||
            exp_q.size() != BLOCK_WORDS) begin
            errors++;
            $display("FAIL slow_fill_hold: got rr/rq/mreq=%b%b%b queued=%0d want 100 queued=%0d",
                     bus.ready_read_o, bus.ready_req_o, bus.mem_req_o, exp_q.size(), BLOCK_WORDS);
        end
        bus.req_i = 1'b1;
        bus.rw_i  = 1'b1;
        step();
        drive_idle();
        checks++;
        if ({bus.mem_req_o, bus.err_o} !== 2'b00) begin
            errors++;
            $display("FAIL blocked_req: got mreq=%b err=%b want 0 0", bus.mem_req_o, bus.err_o);
        end
        for (int i = 0; i < BLOCK_WORDS; i++) begin
            checks++;
            if (bus.ready_read_o !== 1'b1 || bus.data_o !== exp_q[0]) begin
                errors++;
                $display("FAIL slow_drain[%0d]: got rr=%b data=%h want rr=1 data=%h",
                         i, bus.ready_read_o, bus.data_o, exp_q[0]);
            end
            bus.read_i = 1'b1;
            step();
            void'(exp_q.pop_front());
        end
        bus.read_i = 1'b0;
        checks++;
        if ({bus.ready_read_o, bus.ready_req_o, bus.err_o} !== 3'b010) begin
            errors++;
            $display("FAIL slow_fill_done: got rr/rq/err=%b%b%b want 010",
                     bus.ready_read_o, bus.ready_req_o, bus.err_o);
        end
    endtask

    task automatic test_wrap();
        for (int f = 0; f < 3; f++) begin
            send_req(1'b1, 1'b0, BW_ADDR'($urandom));
            ack_after($urandom_range(0, 2));
            read_fill(BLOCK_WORDS, 1, 1'b1);
        end
        checks++;
        if ({bus.err_o, bus.ready_req_o} !== 2'b01) begin
            errors++;
            $display("FAIL wrap_end: got err=%b rq=%b want err=0 rq=1", bus.err_o, bus.ready_req_o);
        end
    endtask

    task automatic test_reset_mid_read();
        send_req(1'b1, 1'b0, BW_ADDR'($urandom));
        ack_after(0);
        read_fill(2, 0, 1'b0);
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        checks++;
        if ({bus.ready_req_o, bus.ready_write_o, bus.ready_read_o, bus.mem_req_o,
             bus.mem_wvalid_o, bus.err_o} !== 6'b100000 || bus.data_o !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got rq/rw/rr/mreq/wv/err=%b%b%b%b%b%b data=%h want 100000 data=0",
                     bus.ready_req_o, bus.ready_write_o, bus.ready_read_o, bus.mem_req_o,
                     bus.mem_wvalid_o, bus.err_o, bus.data_o);
        end
        @(posedge clk);
        #3 rst = 1'b0;
        step();
        send_req(1'b0, 1'b0, BW_ADDR'($urandom));
        ack_after(1);
        read_fill(1, 2, 1'b1);
        checks++;
        if ({bus.ready_req_o, bus.err_o} !== 2'b10) begin
            errors++;
            $display("FAIL post_reset_read: got rq=%b err=%b want 1 0", bus.ready_req_o, bus.err_o);
        end
    endtask

    task automatic test_protocol_errors();
        apply_reset();
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = $urandom;
        step();
        drive_idle();
        repeat (3) step();
        checks++;
        if ({bus.err_o, bus.ready_read_o, bus.ready_req_o} !== 3'b101) begin
            errors++;
            $display("FAIL rvalid_idle: got err/rr/rq=%b%b%b want 101",
                     bus.err_o, bus.ready_read_o, bus.ready_req_o);
        end
        apply_reset();
        bus.read_i = 1'b1;
        step();
        drive_idle();
        repeat (3) step();
        checks++;
        if ({bus.err_o, bus.ready_read_o, bus.ready_req_o} !== 3'b101) begin
            errors++;
            $display("FAIL read_empty: got err/rr/rq=%b%b%b want 101",
                     bus.err_o, bus.ready_read_o, bus.ready_req_o);
        end
        apply_reset();
    endtask

    task automatic test_random_traffic();
        for (int t = 0; t < 8; t++) begin
            logic blk = $urandom_range(0, 1);
            if ($urandom_range(0, 1) == 1) begin
                wq.delete();
                for (int i = 0; i < BLOCK_WORDS; i++) wq.push_back($urandom);
                write_back(blk, $urandom_range(0, 3), 1'b0);
            end else begin
                send_req(blk, 1'b0, BW_ADDR'($urandom));
                ack_after($urandom_range(0, 3));
                read_fill(blk ? BLOCK_WORDS : 1, 2, 1'b1);
            end
        end
        checks++;
        if ({bus.err_o, bus.ready_req_o} !== 2'b01) begin
            errors++;
            $display("FAIL random_end: got err=%b rq=%b want 0 1", bus.err_o, bus.ready_req_o);
        end
    endtask

    initial begin
        drive_idle();
        rst = 1'b1;
        test_reset();
        test_single_read();
        test_block_write();
        test_slow_fill();
        test_wrap();
        test_reset_mid_read();
        test_protocol_errors();
        test_random_traffic();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
